// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizing for the countdown timer slice.
// The FSM state encoding lives here so the top and any future wrappers agree on it.
package countdown_timer_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_EXP_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // True when an unsigned value is at the top of its range.
  function automatic logic is_max(input logic [31:0] value, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == top);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment.
// When clear and inc arrive together the count restarts at one.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_next;

  always_comb begin
    value_next = value;
    if (clear) begin
      value_next = inc ? W'(1) : '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value_next = value + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and terminal-count pulse.
//   state | meaning
//   IDLE  | waiting for a load; count parked (0 after expiry or abort)
//   RUN   | decrementing on enabled cycles; reloads or returns to IDLE at expiry
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned EXP_W = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic [EXP_W-1:0] expiry_cnt
);

  timer_state_t     state;
  timer_state_t     state_next;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] count_next;
  logic             load_fire;
  logic             load_zero;
  logic             expire;

  // Abort masks both the handshake and expiry, so it silently wins any race.
  assign load_fire = load_valid && load_ready;
  assign load_zero = load_fire && (load_value == '0);
  assign expire    = (state == RUN) && enable && (count == WIDTH'(1)) && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (load_fire && !load_zero) state_next = RUN;
        RUN:  if (expire && !mode_reg)     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == RUN);
    load_ready = (state == IDLE) && !abort;
  end

  always_comb begin
    count_next = count;
    if (abort) begin
      count_next = '0;
    end else if (load_fire) begin
      count_next = load_value;
    end else if (expire) begin
      count_next = mode_reg ? reload_reg : '0;
    end else if ((state == RUN) && enable) begin
      count_next = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      tc_pulse   <= 1'b0;
    end else begin
      count    <= count_next;
      tc_pulse <= expire || load_zero;
      if (load_fire) begin
        reload_reg <= load_value;
        mode_reg   <= auto_reload;
      end
    end
  end

  sat_counter #(
    .W(EXP_W)
  ) u_expiry (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (load_fire),
    .inc    (expire || load_zero),
    .value  (expiry_cnt)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus hand-written corner sequences.
// A second instance with a 2-bit expiry counter shares the stimulus for saturation.
module tb_countdown_timer;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [3:0] load_value;
  logic       auto_reload;
  logic       enable;
  logic       abort;
  logic       load_ready, load_ready2;
  logic [3:0] count, count2;
  logic       busy, busy2;
  logic       tc_pulse, tc_pulse2;
  logic [7:0] expiry_cnt;
  logic [1:0] expiry_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit lv;
    int val;
    bit ar;
    bit en;
    bit ab;
    int exp_count;
    bit exp_busy;
    bit exp_tc;
    int exp_exp;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(4), .EXP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_value(load_value),
    .auto_reload(auto_reload), .load_ready(load_ready), .enable(enable), .abort(abort),
    .count(count), .busy(busy), .tc_pulse(tc_pulse), .expiry_cnt(expiry_cnt)
  );

  countdown_timer #(.WIDTH(4), .EXP_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_value(load_value),
    .auto_reload(auto_reload), .load_ready(load_ready2), .enable(enable), .abort(abort),
    .count(count2), .busy(busy2), .tc_pulse(tc_pulse2), .expiry_cnt(expiry_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lv, input int val, input bit ar, input bit en, input bit ab);
    load_valid  = lv;
    load_value  = 4'(val);
    auto_reload = ar;
    enable      = en;
    abort       = ab;
  endtask

  task automatic chk_state(input string tag, input int c, input bit b, input bit tc, input int ex);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " busy"}, int'(busy), int'(b));
    chk({tag, " tc_pulse"}, int'(tc_pulse), int'(tc));
    chk({tag, " expiry_cnt"}, int'(expiry_cnt), ex);
  endtask

  function automatic void add(input bit lv, input int val, input bit ar, input bit en,
                              input bit ab, input int c, input bit b, input bit tc, input int ex);
    vec_t v;
    v.lv = lv; v.val = val; v.ar = ar; v.en = en; v.ab = ab;
    v.exp_count = c; v.exp_busy = b; v.exp_tc = tc; v.exp_exp = ex;
    vecs.push_back(v);
  endfunction

  initial begin
    // One-shot load 5
    add(1, 5, 0, 1, 0, 5, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1);
    // Auto-reload load 3 with enable gaps, four periods
    add(1, 3, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3, 1, 1, 1);
    add(0, 0, 0, 1, 0, 2, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 3, 1, 1, 2);
    add(0, 0, 0, 0, 0, 3, 1, 0, 2);
    add(0, 0, 0, 1, 0, 2, 1, 0, 2);
    add(0, 0, 0, 1, 0, 1, 1, 0, 2);
    add(0, 0, 0, 1, 0, 3, 1, 1, 3);
    add(0, 0, 0, 1, 0, 2, 1, 0, 3);
    add(0, 0, 0, 1, 0, 1, 1, 0, 3);
    add(0, 0, 0, 1, 0, 3, 1, 1, 4);
    add(0, 0, 0, 1, 0, 2, 1, 0, 4);
    // Abort keeps expiry count
    add(0, 0, 0, 1, 1, 0, 0, 0, 4);
    // Zero load: no RUN, immediate pulse
    add(1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset load_ready", int'(load_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a run
    #1;
    drive(1, 9, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    repeat (3) tick();
    chk("midrun count before reset", int'(count), 6);
    #1;
    reset_n = 1'b0;
    #1;
    chk_state("async reset", 0, 0, 0, 0);
    chk("async reset load_ready", int'(load_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].val, vecs[i].ar, vecs[i].en, vecs[i].ab);
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
                vecs[i].exp_tc, vecs[i].exp_exp);
    end

    // Max load: expiry after exactly 15 enabled cycles
    drive(1, 15, 0, 1, 0);
    tick();
    chk_state("max load", 15, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 14; k >= 1; k--) begin
      tick();
      chk("max count", int'(count), k);
      chk("max tc", int'(tc_pulse), 0);
    end
    tick();
    chk_state("max expiry", 0, 0, 1, 1);

    // Abort on the same edge as the count==1 expiry
    drive(1, 2, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    chk("race pre count", int'(count), 1);
    drive(0, 0, 0, 1, 1);
    tick();
    chk_state("abort race", 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("abort race tc after", int'(tc_pulse), 0);

    // Abort with load_valid in IDLE blocks the load
    drive(1, 7, 0, 1, 1);
    #1;
    chk("abort ready", int'(load_ready), 0);
    tick();
    chk("abort load count", int'(count), 0);
    chk("abort load busy", int'(busy), 0);

    // load_valid held through RUN is only taken after abort returns to IDLE
    drive(1, 4, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    chk("hs count", int'(count), 3);
    drive(1, 9, 0, 0, 0);
    #1;
    chk("hs ready in run", int'(load_ready), 0);
    repeat (3) tick();
    chk("hs held count", int'(count), 3);
    chk("hs held busy", int'(busy), 1);
    drive(1, 9, 0, 0, 1);
    tick();
    chk("hs abort count", int'(count), 0);
    chk("hs abort busy", int'(busy), 0);
    drive(1, 9, 0, 0, 0);
    tick();
    chk("hs accepted count", int'(count), 9);
    chk("hs accepted busy", int'(busy), 1);

    // Saturation on the 2-bit expiry counter with period-1 auto reload
    drive(0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 1, 1, 0);
    tick();
    chk("sat load exp", int'(expiry_cnt2), 0);
    chk("sat load count", int'(count2), 1);
    drive(0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("sat exp%0d", k), int'(expiry_cnt2), (k > 3) ? 3 : k);
      chk($sformatf("sat tc%0d", k), int'(tc_pulse2), 1);
      chk($sformatf("sat busy%0d", k), int'(busy2), 1);
      chk($sformatf("sat count%0d", k), int'(count2), 1);
    end
    chk("wide exp no sat", int'(expiry_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
